// File: rtl/div_iter.sv
// Iterative restoring divider: one quotient bit per cycle on operand magnitudes,
// signed (truncating) or unsigned, with annul and divide-by-zero handling.
module div_iter #(
    parameter int WIDTH = 32
) (
    input  logic               clk,
    input  logic               resetn,
    input  logic               start,
    input  logic               signed_div,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    input  logic               annul,
    output logic               busy,
    output logic               valid,
    output logic [2*WIDTH-1:0] result,
    output logic               div_by_zero
);

    localparam int            CW   = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        DONE
    } state_t;

    state_t           state;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] rem;
    logic [WIDTH-1:0] quo;
    logic [WIDTH-1:0] dvs;
    logic             neg_q;
    logic             neg_r;

    logic [WIDTH-1:0] a_mag;
    logic [WIDTH-1:0] b_mag;
    logic [WIDTH:0]   shifted;
    logic [WIDTH:0]   diff;
    logic [WIDTH-1:0] rem_nxt;
    logic [WIDTH-1:0] quo_nxt;
    logic [WIDTH-1:0] q_final;
    logic [WIDTH-1:0] r_final;

    // quo starts as the dividend magnitude and fills with quotient bits from the right;
    // a clear top bit of diff means the trial subtraction fits.
    always_comb begin
        a_mag   = (signed_div && a[WIDTH-1]) ? -a : a;
        b_mag   = (signed_div && b[WIDTH-1]) ? -b : b;
        shifted = {rem, quo[WIDTH-1]};
        diff    = shifted - {1'b0, dvs};
        if (!diff[WIDTH]) begin
            rem_nxt = diff[WIDTH-1:0];
            quo_nxt = {quo[WIDTH-2:0], 1'b1};
        end else begin
            rem_nxt = shifted[WIDTH-1:0];
            quo_nxt = {quo[WIDTH-2:0], 1'b0};
        end
        q_final = neg_q ? -quo_nxt : quo_nxt;
        r_final = neg_r ? -rem_nxt : rem_nxt;
    end

    always_ff @(posedge clk) begin
        // NOTE: synchronous reset clears datapath too so result reads 0; <= keeps all updates parallel.
        if (!resetn) begin
            state       <= IDLE;
            cnt         <= '0;
            busy        <= 1'b0;
            valid       <= 1'b0;
            result      <= '0;
            div_by_zero <= 1'b0;
            rem         <= '0;
            quo         <= '0;
            dvs         <= '0;
            neg_q       <= 1'b0;
            neg_r       <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    valid <= 1'b0;
                    busy  <= 1'b0;
                    if (start && !annul) begin
                        cnt   <= '0;
                        rem   <= '0;
                        quo   <= a_mag;
                        dvs   <= b_mag;
                        neg_q <= signed_div && (a[WIDTH-1] ^ b[WIDTH-1]);
                        neg_r <= signed_div && a[WIDTH-1];
                        busy  <= 1'b1;
                        if (b == '0) begin
                            state       <= DONE;
                            valid       <= 1'b1;
                            result      <= {a, {WIDTH{1'b1}}};
                            div_by_zero <= 1'b1;
                        end else begin
                            state <= CALC;
                        end
                    end
                end
                CALC: begin
                    if (annul) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end else begin
                        rem <= rem_nxt;
                        quo <= quo_nxt;
                        cnt <= cnt + 1'b1;
                        if (cnt == LAST) begin
                            state       <= DONE;
                            valid       <= 1'b1;
                            result      <= {r_final, q_final};
                            div_by_zero <= 1'b0;
                        end
                    end
                end
                DONE: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    valid <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_div_iter.sv
// Bench for div_iter: directed table at WIDTH=32 plus annul/reset sequences,
// and random WIDTH=8 operations checked against an arithmetic reference model.
module tb_div_iter;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;

    logic        start, sd, annul;
    logic [31:0] a, b;
    logic        busy, valid, dbz;
    logic [63:0] result;

    logic        start8, sd8, annul8;
    logic [7:0]  a8, b8;
    logic        busy8, valid8, dbz8;
    logic [15:0] result8;

    int          n_checks = 0;
    int          n_err = 0;
    logic [63:0] last_exp = '0;

    typedef struct {
        string       name;
        bit          s;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] q;
        logic [31:0] r;
        bit          dbz;
    } vec_t;

    vec_t vecs[10];

    div_iter #(.WIDTH(32)) dut32 (
        .clk(clk), .resetn(resetn), .start(start), .signed_div(sd), .a(a), .b(b),
        .annul(annul), .busy(busy), .valid(valid), .result(result), .div_by_zero(dbz)
    );

    div_iter #(.WIDTH(8)) dut8 (
        .clk(clk), .resetn(resetn), .start(start8), .signed_div(sd8), .a(a8), .b(b8),
        .annul(annul8), .busy(busy8), .valid(valid8), .result(result8), .div_by_zero(dbz8)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Truncating division on plain integers; w-bit two's-complement wrap via masking.
    function automatic void ref_div(input bit s, input longint av, input longint bv, input int w,
                                    output longint q, output longint r);
        longint m, x, y;
        m = (longint'(1) << w) - 1;
        x = av;
        y = bv;
        if (s && x >= (longint'(1) << (w - 1))) x = x - (longint'(1) << w);
        if (s && y >= (longint'(1) << (w - 1))) y = y - (longint'(1) << w);
        if (bv == 0) begin
            q = m;
            r = av;
        end else begin
            q = (x / y) & m;
            r = (x % y) & m;
        end
    endfunction

    // Starts one 32-bit op from IDLE; returns one cycle after DONE, so the next call is back-to-back.
    task automatic run_op(input string name, input bit s, input logic [31:0] av, input logic [31:0] bv,
                          input logic [31:0] qe, input logic [31:0] re, input bit de);
        int cyc;
        int lat_exp;
        bit bad_busy;
        lat_exp = (bv == 0) ? 1 : 33;
        sd = s; a = av; b = bv; start = 1'b1;
        tick();
        cyc = 1;
        start = 1'b0;
        a = $urandom; b = $urandom; sd = 1'($urandom);
        bad_busy = 1'b0;
        while (!valid && cyc < 100) begin
            if (!busy) bad_busy = 1'b1;
            start = (cyc == 3);
            tick();
            cyc++;
        end
        start = 1'b0;
        check({name, " latency"}, 64'(cyc), 64'(lat_exp));
        check({name, " busy in flight"}, {63'd0, bad_busy}, 64'd0);
        check({name, " busy at valid"}, {63'd0, busy}, 64'd1);
        check({name, " result"}, result, {re, qe});
        check({name, " div_by_zero"}, {63'd0, dbz}, {63'd0, de});
        tick();
        check({name, " idle after done"}, {62'd0, busy, valid}, 64'd0);
        check({name, " result held"}, result, {re, qe});
        last_exp = {re, qe};
    endtask

    initial begin
        int cyc;
        bit bad;
        longint q, r;
        bit s;
        logic [7:0] av, bv;

        vecs[0] = '{"divu 100/7",      1'b0, 32'd100,       32'd7,         32'd14,        32'd2,         1'b0};
        vecs[1] = '{"div -7/2",        1'b1, 32'hFFFFFFF9,  32'd2,         32'hFFFFFFFD,  32'hFFFFFFFF,  1'b0};
        vecs[2] = '{"div 7/-2",        1'b1, 32'd7,         32'hFFFFFFFE,  32'hFFFFFFFD,  32'd1,         1'b0};
        vecs[3] = '{"div minneg/-1",   1'b1, 32'h80000000,  32'hFFFFFFFF,  32'h80000000,  32'd0,         1'b0};
        vecs[4] = '{"divu minneg/-1",  1'b0, 32'h80000000,  32'hFFFFFFFF,  32'd0,         32'h80000000,  1'b0};
        vecs[5] = '{"divu 5/0",        1'b0, 32'd5,         32'd0,         32'hFFFFFFFF,  32'd5,         1'b1};
        vecs[6] = '{"div 5/0",         1'b1, 32'd5,         32'd0,         32'hFFFFFFFF,  32'd5,         1'b1};
        vecs[7] = '{"div -100/-7",     1'b1, 32'hFFFFFF9C,  32'hFFFFFFF9,  32'd14,        32'hFFFFFFFE,  1'b0};
        vecs[8] = '{"divu max/1",      1'b0, 32'hFFFFFFFF,  32'd1,         32'hFFFFFFFF,  32'd0,         1'b0};
        vecs[9] = '{"divu 3/10",       1'b0, 32'd3,         32'd10,        32'd0,         32'd3,         1'b0};

        start = 1'b1; sd = 1'b0; annul = 1'b0; a = 32'd5; b = 32'd0;
        start8 = 1'b0; sd8 = 1'b0; annul8 = 1'b0; a8 = '0; b8 = '0;

        // Reset held with start asserted: nothing may begin.
        tick();
        tick();
        check("reset busy/valid/dbz", {61'd0, busy, valid, dbz}, 64'd0);
        check("reset result", result, 64'd0);
        start = 1'b0;
        resetn = 1'b1;
        tick();

        foreach (vecs[i])
            run_op(vecs[i].name, vecs[i].s, vecs[i].a, vecs[i].b, vecs[i].q, vecs[i].r, vecs[i].dbz);

        // annul and start together in IDLE: annul wins.
        sd = 1'b0; a = 32'd5; b = 32'd0; start = 1'b1; annul = 1'b1;
        tick();
        start = 1'b0; annul = 1'b0;
        check("idle annul+start busy/valid", {62'd0, busy, valid}, 64'd0);
        tick();
        check("idle annul+start no valid", {62'd0, busy, valid}, 64'd0);
        check("idle annul+start result", result, last_exp);

        // annul at edge 10 of an operation, then a fresh start at edge 11.
        sd = 1'b0; a = 32'd1000; b = 32'd3; start = 1'b1;
        tick();
        cyc = 1;
        start = 1'b0;
        bad = 1'b0;
        while (cyc < 10) begin
            if (valid) bad = 1'b1;
            tick();
            cyc++;
        end
        annul = 1'b1;
        tick();
        annul = 1'b0;
        check("annul no early valid", {63'd0, bad}, 64'd0);
        check("annul busy/valid", {62'd0, busy, valid}, 64'd0);
        check("annul result held", result, last_exp);
        check("annul dbz held", {63'd0, dbz}, {63'd0, last_exp[31:0] == 32'd3 && last_exp[63:32] == 32'd0 ? 1'b0 : dbz});
        run_op("after annul 9/3", 1'b0, 32'd9, 32'd3, 32'd3, 32'd0, 1'b0);

        // Reset at edge 20 of an operation, start again at edge 22.
        sd = 1'b1; a = 32'd1000; b = 32'd3; start = 1'b1;
        tick();
        cyc = 1;
        start = 1'b0;
        while (cyc < 20) begin
            tick();
            cyc++;
        end
        resetn = 1'b0;
        tick();
        check("midop reset busy/valid/dbz", {61'd0, busy, valid, dbz}, 64'd0);
        check("midop reset result", result, 64'd0);
        resetn = 1'b1;
        tick();
        check("after reset no valid", {62'd0, busy, valid}, 64'd0);
        run_op("after reset divu 100/7", 1'b0, 32'd100, 32'd7, 32'd14, 32'd2, 1'b0);

        // Random WIDTH=8 operations against the reference model.
        for (int i = 0; i < 300; i++) begin
            s  = 1'($urandom);
            av = 8'($urandom);
            bv = ($urandom_range(0, 9) == 0) ? 8'd0 : 8'($urandom);
            if (i % 50 == 0) begin
                av = 8'h80;
                bv = 8'hFF;
            end
            ref_div(s, longint'(av), longint'(bv), 8, q, r);
            sd8 = s; a8 = av; b8 = bv; start8 = 1'b1;
            tick();
            cyc = 1;
            start8 = 1'b0;
            a8 = 8'($urandom); b8 = 8'($urandom);
            while (!valid8 && cyc < 40) begin
                tick();
                cyc++;
            end
            check($sformatf("rnd%0d latency s=%0d a=%h b=%h", i, s, av, bv),
                  64'(cyc), (bv == 0) ? 64'd1 : 64'd9);
            check($sformatf("rnd%0d s=%0d a=%h b=%h", i, s, av, bv),
                  {47'd0, dbz8, result8}, {47'd0, bv == 8'd0, r[7:0], q[7:0]});
            tick();
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule

// File: doc/div_iter.md
DIV_ITER -- requirements
Module: div_iter

Interface
REQ-001 SHALL have parameter WIDTH, default 32, meaning the operand width in bits; legal values are 2 to 64.
REQ-002 SHALL have port clk, input, 1 bit, meaning the single clock; all state changes on its rising edge.
REQ-003 SHALL have port resetn, input, 1 bit, meaning reset; it is synchronous and active-low.
REQ-004 SHALL have port start, input, 1 bit, meaning a request to begin a division; it is sampled only in IDLE.
REQ-005 SHALL have port signed_div, input, 1 bit, with 1 = signed (DIV) and 0 = unsigned (DIVU); it is sampled with start.
REQ-006 SHALL have port a, input, WIDTH bits, meaning the dividend; it is sampled with start.
REQ-007 SHALL have port b, input, WIDTH bits, meaning the divisor; it is sampled with start.
REQ-008 SHALL have port annul, input, 1 bit, meaning a pipeline flush that abandons the current operation.
REQ-009 SHALL have port busy, output, 1 bit, which is high while an operation is in flight; it drives the pipeline stall.
REQ-010 SHALL have port valid, output, 1 bit, meaning a one-cycle pulse that flags result as new.
REQ-011 SHALL have port result, output, 2*WIDTH bits, with [2W-1:W] = remainder (HI) and [W-1:0] = quotient (LO).
REQ-012 SHALL have port div_by_zero, output, 1 bit, which is high with valid when b was 0.

Function
REQ-013 SHALL implement a state machine with states IDLE, CALC and DONE.
REQ-014 SHALL register a, b and signed_div and leave IDLE when in IDLE with start=1 and annul=0 at edge 0.
REQ-015 SHALL go to CALC after the edge-0 capture when b!=0, or directly to DONE when b==0.
REQ-016 SHALL, in CALC, perform one restoring shift/subtract step per cycle on operand magnitudes, for exactly WIDTH cycles, using an iteration counter.
REQ-017 SHALL go from CALC to DONE after the WIDTH-th step, and from DONE to IDLE unconditionally.
REQ-018 SHALL hold busy=1 in CALC and DONE, and busy=0 in IDLE.
REQ-019 SHALL hold valid=1 only in DONE, so valid is a single-cycle pulse.
REQ-020 SHALL assert valid WIDTH+1 cycles after the start edge when b!=0, and 1 cycle after when b==0.
REQ-021 SHALL, in unsigned mode, compute quotient = floor(a/b) and remainder = a mod b.
REQ-022 SHALL, in signed mode, truncate toward zero: remainder takes the dividend's sign, quotient is negated if sign(a) xor sign(b), and the result satisfies a = q*b + r.
REQ-023 SHALL, for signed a = most-negative value and b = -1, give quotient = most-negative value and remainder = 0 (two's-complement wrap, no trap).
REQ-024 SHALL, when b==0, give quotient = all ones, remainder = a unmodified, and div_by_zero=1, in both modes.
REQ-025 SHALL load result and div_by_zero only on entry to DONE and hold them otherwise, including across later IDLE cycles.
REQ-026 SHALL ignore start while in CALC or DONE, with no queuing.
REQ-027 SHALL return to IDLE on the next edge when annul=1 in CALC or DONE, with no valid pulse and with result and div_by_zero unchanged.
REQ-028 SHALL give annul priority when annul=1 and start=1 in the same IDLE cycle, so no operation starts.
REQ-029 SHALL accept a new start on the cycle after DONE (back-to-back operations), giving a minimum issue interval of WIDTH+2 cycles.
REQ-030 SHALL keep operand registers live only from capture to DONE, so a/b changes after the start edge have no effect.

Reset
REQ-031 SHALL, on resetn=0 at a rising edge, force state IDLE, counter 0, busy=0, valid=0, result=0 and div_by_zero=0.
REQ-032 SHALL treat reset mid-operation (CALC or DONE) as abandoning that operation, with no valid pulse afterward.
REQ-033 SHALL give reset priority over start and annul.
REQ-034 SHALL ignore start while resetn=0.

Verification
REQ-035 SHALL be verified by this directed scenario: WIDTH=32, unsigned, a=100, b=7, start at edge 0 -> valid at edge 33 with result = {32'd2, 32'd14}, div_by_zero=0, and busy high for edges 1..33.
REQ-036 SHALL be verified by this directed scenario: signed, a=-7 (0xFFFFFFF9), b=2 -> quotient 0xFFFFFFFD, remainder 0xFFFFFFFF; and a=7, b=-2 -> quotient 0xFFFFFFFD, remainder 0x00000001.
REQ-037 SHALL be verified by this directed scenario: signed, a=0x80000000, b=0xFFFFFFFF -> quotient 0x80000000, remainder 0; the unsigned version of the same operands -> quotient 0, remainder 0x80000000.
REQ-038 SHALL be verified by this directed scenario: a=5, b=0, either mode -> valid at edge 1, quotient 0xFFFFFFFF, remainder 5, div_by_zero=1, and busy=0 at edge 2.
REQ-039 SHALL be verified by this directed scenario: start at edge 0, annul at edge 10 -> busy=0 from edge 11, no valid, result holds its previous value; then start at edge 11 with 9/3 -> valid at edge 44 with {0, 3}.
REQ-040 SHALL be verified by this directed scenario: resetn=0 at edge 20 of an operation -> all outputs zero at edge 21, no valid, and a start at edge 22 proceeds normally; plus WIDTH=8 random signed/unsigned operands checked against a reference model.
